// File: rtl/exec_alu.sv
// exec_alu: single-issue integer execute stage with a valid/ready handshake on both sides.
// Single-cycle ALU ops (ADD..SLTU) land in DONE on the accepting edge; results are held
// in DONE until the consumer takes them, and a new op may be accepted on the retiring edge.
// Optional feature: define EXEC_ALU_MUL_EN to build the iterative shift-add multiplier
// (opcode 10, CALC state). Without it opcode 10 is reported as illegal.
module exec_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             I_valid,
    output logic             O_ready,
    input  logic [3:0]       I_op,
    input  logic [WIDTH-1:0] I_A,
    input  logic [WIDTH-1:0] I_B,
    input  logic [TAG_W-1:0] I_rd,
    output logic             O_valid,
    input  logic             I_ready,
    output logic [WIDTH-1:0] O_result,
    output logic [TAG_W-1:0] O_rd,
    output logic             O_illegal
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    accept;
    logic                    is_mul;
    logic                    mul_done;
    logic                    op_illegal;
    logic [WIDTH-1:0]        mul_res;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;

    // Single-cycle ALU; illegal opcodes fall through to zero.
    function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
        logic [4:0]       sh;
        logic [WIDTH-1:0] r;
        sh = b[4:0];
        r  = '0;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = $unsigned(a) >> sh;
            4'd7:    r = a >>> sh;
            4'd8:    r = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd9:    r = {{(WIDTH-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign a_s        = I_A;
    assign b_s        = I_B;
    assign accept     = I_valid && O_ready;
    assign op_illegal = (I_op > 4'd9) && !is_mul;
    assign O_valid    = (state == DONE);

`ifdef EXEC_ALU_MUL_EN
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_acc;
    logic [CNT_W-1:0] mul_cnt;

    assign is_mul   = (I_op == 4'd10);
    // The last CALC cycle folds its own partial product straight into the result.
    assign mul_done = (state == CALC) && (mul_cnt == CNT_LAST);
    assign mul_res  = mul_acc + (mul_b[0] ? mul_a : '0);

    // Shift-add multiplier: one multiplier bit consumed per CALC cycle, WIDTH cycles total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (accept && is_mul) begin
            mul_a   <= I_A;
            mul_b   <= I_B;
            mul_acc <= '0;
            mul_cnt <= '0;
        end else if (state == CALC) begin
            mul_acc <= mul_res;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and ready: CALC blocks new work, DONE only accepts while retiring.
    always_comb begin
        state_next = state;
        O_ready    = 1'b0;
        case (state)
            IDLE: begin
                O_ready = 1'b1;
                if (I_valid) state_next = is_mul ? CALC : DONE;
            end
            CALC: begin
                if (mul_done) state_next = DONE;
            end
            DONE: begin
                O_ready = I_ready;
                if (I_ready) begin
                    if (!I_valid)    state_next = IDLE;
                    else if (is_mul) state_next = CALC;
                    else             state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers: loaded on accept (ALU) or at the end of CALC (MUL), else held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            O_result  <= '0;
            O_rd      <= '0;
            O_illegal <= 1'b0;
        end else if (accept) begin
            O_rd      <= I_rd;
            O_illegal <= op_illegal;
            if (!is_mul) O_result <= alu_calc(I_op, a_s, b_s);
        end else if (mul_done) begin
            O_result  <= mul_res;
        end
    end

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: randomized and directed checks of exec_alu against a behavioural model.
// Honours EXEC_ALU_MUL_EN the same way as the design.
module tb_exec_alu;

`ifdef EXEC_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        I_valid;
    logic        O_ready;
    logic [3:0]  I_op;
    logic [31:0] I_A;
    logic [31:0] I_B;
    logic [11:0] I_rd;
    logic        O_valid;
    logic        I_ready;
    logic [31:0] O_result;
    logic [11:0] O_rd;
    logic        O_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  q_op[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_exp[$];
    logic        q_ill[$];

    exec_alu #(.WIDTH(32), .TAG_W(12)) dut (
        .clk(clk), .rst(rst),
        .I_valid(I_valid), .O_ready(O_ready),
        .I_op(I_op), .I_A(I_A), .I_B(I_B), .I_rd(I_rd),
        .O_valid(O_valid), .I_ready(I_ready),
        .O_result(O_result), .O_rd(O_rd), .O_illegal(O_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from the opcode table, using plain integer arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic ill);
        int unsigned     sh;
        longint unsigned p;
        logic [31:0]     r;
        sh  = b % 32;
        ill = 1'b0;
        r   = 32'h0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin
                if (MUL_EN) begin
                    p = 64'(a) * 64'(b);
                    r = p[31:0];
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        return r;
    endfunction

    // One isolated op from IDLE: accept, latency, hold under backpressure, retire.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [11:0] rd, input int stall, input bit use_exp,
                          input logic [31:0] exp_in, input logic ill_in);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          lat;
        int          first;
        exp_res = ref_alu(op, a, b, exp_ill);
        if (use_exp) begin
            exp_res = exp_in;
            exp_ill = ill_in;
        end
        lat = (MUL_EN && op == 4'd10) ? 33 : 1;
        check_eq($sformatf("ready_idle op%0d", op), O_ready, 1);
        I_valid = 1'b1; I_op = op; I_A = a; I_B = b; I_rd = rd; I_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        I_valid = 1'b0;
        first = -1;
        for (int j = 0; j < lat + 4 && first < 0; j++) begin
            if (O_valid) begin
                first = j;
            end else begin
                I_valid = 1'($urandom_range(0, 1));
                I_op    = 4'($urandom_range(0, 15));
                I_A     = $urandom;
                I_B     = $urandom;
                I_rd    = 12'($urandom);
                @(negedge clk);
            end
        end
        I_valid = 1'b0;
        check_eq($sformatf("latency op%0d", op), 64'(first), 64'(lat - 1));
        for (int s = 0; s <= stall; s++) begin
            check_eq($sformatf("valid op%0d", op), O_valid, 1);
            check_eq($sformatf("result op%0d a=%0h b=%0h", op, a, b), O_result, exp_res);
            check_eq($sformatf("rd op%0d", op), O_rd, rd);
            check_eq($sformatf("illegal op%0d", op), O_illegal, exp_ill);
            check_eq($sformatf("ready_stall op%0d", op), O_ready, 0);
            if (s < stall) @(negedge clk);
        end
        I_ready = 1'b1;
        #1;
        check_eq($sformatf("ready_retire op%0d", op), O_ready, 1);
        @(negedge clk);
        I_ready = 1'b0;
        #1;
        check_eq($sformatf("drop_valid op%0d", op), O_valid, 0);
        check_eq($sformatf("ready_after op%0d", op), O_ready, 1);
        @(negedge clk);
    endtask

    // Back-to-back stream of single-cycle ops with I_valid and I_ready held high.
    task automatic run_b2b();
        I_ready = 1'b1;
        for (int i = 0; i < q_op.size(); i++) begin
            I_valid = 1'b1; I_op = q_op[i]; I_A = q_a[i]; I_B = q_b[i]; I_rd = 12'(i + 20);
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("b2b valid #%0d", i), O_valid, 1);
            check_eq($sformatf("b2b result #%0d op%0d", i, q_op[i]), O_result, q_exp[i]);
            check_eq($sformatf("b2b rd #%0d", i), O_rd, 64'(i + 20));
            check_eq($sformatf("b2b illegal #%0d", i), O_illegal, q_ill[i]);
        end
        I_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b drain", O_valid, 0);
        I_ready = 1'b0;
        q_op.delete(); q_a.delete(); q_b.delete(); q_exp.delete(); q_ill.delete();
    endtask

    task automatic push_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        ill;
        logic [31:0] r;
        r = ref_alu(op, a, b, ill);
        q_op.push_back(op); q_a.push_back(a); q_b.push_back(b);
        q_exp.push_back(r); q_ill.push_back(ill);
    endtask

    initial begin
        int vcount;
        logic [3:0] rop;
        rst = 1'b1; I_valid = 1'b0; I_op = '0; I_A = '0; I_B = '0; I_rd = '0; I_ready = 1'b0;
        #2;
        check_eq("reset valid", O_valid, 0);
        check_eq("reset result", O_result, 0);
        check_eq("reset rd", O_rd, 0);
        check_eq("reset illegal", O_illegal, 0);
        check_eq("reset ready", O_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed ALU cases.
        run_op(4'd0, 32'd57, 32'd567, 12'd6, 0, 1'b1, 32'd624, 1'b0);
        run_op(4'd1, 32'd0, 32'd1, 12'd1, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd7, 32'h8000_0000, 32'd4, 12'd2, 0, 1'b1, 32'hF800_0000, 1'b0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 12'd3, 0, 1'b1, 32'd1, 1'b0);
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 12'd4, 0, 1'b1, 32'd0, 1'b0);
        // Backpressure: five stalled cycles.
        run_op(4'd0, 32'd3, 32'd1, 12'd5, 5, 1'b1, 32'd4, 1'b0);
        // Illegal opcodes.
        run_op(4'd13, 32'h1234, 32'h5678, 12'd7, 1, 1'b1, 32'd0, 1'b1);
        if (MUL_EN) run_op(4'd10, 32'd1234, 32'd5678, 12'd9, 2, 1'b1, 32'd7006652, 1'b0);
        else        run_op(4'd10, 32'd1234, 32'd5678, 12'd9, 0, 1'b1, 32'd0, 1'b1);

        // Back-to-back directed chain.
        q_op.push_back(4'd0); q_a.push_back(32'd1); q_b.push_back(32'd2); q_exp.push_back(32'd3); q_ill.push_back(1'b0);
        q_op.push_back(4'd4); q_a.push_back(32'd5); q_b.push_back(32'd3); q_exp.push_back(32'd6); q_ill.push_back(1'b0);
        q_op.push_back(4'd3); q_a.push_back(32'd8); q_b.push_back(32'd1); q_exp.push_back(32'd9); q_ill.push_back(1'b0);
        run_b2b();

        // Reset in the middle of work: everything clears at once, nothing stale afterwards.
        I_valid = 1'b1; I_ready = 1'b0; I_rd = 12'd77;
        if (MUL_EN) begin
            I_op = 4'd10; I_A = 32'd1234; I_B = 32'd5678;
        end else begin
            I_op = 4'd0; I_A = 32'd7; I_B = 32'd8;
        end
        @(posedge clk);
        @(negedge clk);
        I_valid = 1'b0;
        if (MUL_EN) begin
            repeat (9) @(negedge clk);
            check_eq("mid-mul valid", O_valid, 0);
            check_eq("mid-mul ready", O_ready, 0);
        end else begin
            check_eq("pre-reset valid", O_valid, 1);
        end
        rst = 1'b1;
        #1;
        check_eq("async rst valid", O_valid, 0);
        check_eq("async rst result", O_result, 0);
        check_eq("async rst rd", O_rd, 0);
        check_eq("async rst illegal", O_illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post-rst ready", O_ready, 1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (O_valid) vcount++;
        end
        check_eq("no stale result", 64'(vcount), 0);

        // Randomized isolated ops with random backpressure.
        for (int i = 0; i < 30; i++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 12'($urandom),
                   int'($urandom_range(0, 3)), 1'b0, 32'd0, 1'b0);
        end
        // Small shift amounts exercise the shift paths meaningfully.
        for (int i = 0; i < 6; i++) begin
            run_op(4'(5 + (i % 3)), $urandom, 32'($urandom_range(0, 31)), 12'(i), 0, 1'b0, 32'd0, 1'b0);
        end

        // Randomized back-to-back chain (no multiplies, those cannot stream).
        for (int i = 0; i < 20; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (MUL_EN && rop == 4'd10) rop = 4'd4;
            push_op(rop, $urandom, $urandom);
        end
        run_b2b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_alu.md
EXEC_ALU -- requirements
Module: exec_alu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL provide parameter TAG_W, default 12, destination-tag width (matches register-read address width).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port I_valid  input  1  upstream (register-read stage) presents an operation.
REQ-006 SHALL provide port O_ready  output  1  block can accept an operation this cycle.
REQ-007 SHALL provide port I_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL, 11-15 illegal.
REQ-008 SHALL provide port I_A  input  WIDTH  operand 1 (register-read O_bit1).
REQ-009 SHALL provide port I_B  input  WIDTH  operand 2 (register-read O_bit2).
REQ-010 SHALL provide port I_rd  input  TAG_W  destination tag, passed through unchanged.
REQ-011 SHALL provide port O_valid  output  1  result available.
REQ-012 SHALL provide port I_ready  input  1  downstream accepts result.
REQ-013 SHALL provide port O_result  output  WIDTH  result.
REQ-014 SHALL provide port O_rd  output  TAG_W  tag of the result.
REQ-015 SHALL provide port O_illegal  output  1  result came from an illegal/unsupported opcode.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL accept an operation on a rising edge where I_valid && O_ready; I_A, I_B, I_op, I_rd captured on that edge.
REQ-018 SHALL drive O_ready = 1 in IDLE, = I_ready in DONE, = 0 in CALC.
REQ-019 SHALL, for opcodes 0-9, move to DONE on the accepting edge with result registered; O_valid high the following cycle (latency 1).
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH with carry discarded; shifts use I_B[4:0]; SRA sign-fills; SLT signed, SLTU unsigned, result 1 or 0 zero-extended.
REQ-021 SHALL, for MUL, enter CALC and run a shift-add multiplier one bit per cycle for exactly WIDTH cycles, then enter DONE; O_result = low WIDTH bits of I_A*I_B; latency WIDTH+1 cycles from accept to O_valid.
REQ-022 SHALL hold O_valid, O_result, O_rd, O_illegal stable in DONE until I_ready=1.
REQ-023 SHALL, in DONE with I_ready=1 and I_valid=0, return to IDLE and drop O_valid next cycle.
REQ-024 SHALL, in DONE with I_ready=1 and I_valid=1, retire the current result and accept the new operation on the same edge (back-to-back, no bubble for 1-cycle ops).
REQ-025 SHALL, for illegal opcodes, enter DONE with O_result=0 and O_illegal=1 at latency 1.
REQ-026 SHALL ignore I_valid while in CALC; inputs changing during CALC do not affect the result.

Reset
REQ-027 SHALL, on rst=1 at any time, immediately force state IDLE, O_valid=0, O_result=0, O_rd=0, O_illegal=0, multiplier registers 0.
REQ-028 SHALL abort an in-progress MUL on reset with no result produced; O_ready=1 the first cycle after rst deasserts.

Configuration
REQ-029 SHALL compile the multiplier (CALC state and MUL datapath) only when macro EXEC_ALU_MUL_EN is defined.
REQ-030 SHALL, without EXEC_ALU_MUL_EN, treat opcode 10 as illegal (REQ-025) and never enter CALC.

Verification
REQ-031 SHALL verify reset: rst pulse mid-MUL (cycle 10 of CALC) -> O_valid=0, O_result=0 immediately, O_ready=1 after release, no stale result.
REQ-032 SHALL verify ALU: ADD 57+567, rd=6 -> O_valid next cycle, O_result=624, O_rd=6; SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000 by 4 -> 0xF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
REQ-033 SHALL verify backpressure: ADD 3+1 with I_ready=0 for 5 cycles -> O_valid/O_result=4 held stable, O_ready=0; I_ready=1 -> retire, O_ready=1.
REQ-034 SHALL verify back-to-back: I_valid and I_ready held 1, ops ADD 1+2, XOR 5^3, OR 8|1 -> results 3, 6, 9 on three consecutive cycles.
REQ-035 SHALL verify MUL with EXEC_ALU_MUL_EN: 1234*5678 accepted at edge k -> O_valid at edge k+33, O_result=7006652; I_valid pulses during CALC ignored.
REQ-036 SHALL verify illegal op: I_op=13, and I_op=10 without EXEC_ALU_MUL_EN -> O_result=0, O_illegal=1 at latency 1.
